// File: rtl/nbit_pkg.sv
// Shared types and constants for the sequential N-bit adder/subtractor.
package nbit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage : nbit_pkg

// File: rtl/chunk_adder.sv
// Combinational W-bit ripple adder slice with carry in/out.
module chunk_adder #(
  parameter int W = 1
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  assign {cout, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};

endmodule : chunk_adder

// File: rtl/nbit_addsub_seq.sv
// Multi-cycle N-bit adder/subtractor, CHUNK bits per clock, with N/Z/C/V flags
// and valid/ready handshakes on both the operand and result sides.
module nbit_addsub_seq
  import nbit_pkg::*;
#(
  parameter int N     = 4,
  parameter int CHUNK = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] r,
  output logic [3:0]   f
);

  localparam int K  = N / CHUNK;
  localparam int IW = $clog2(K) + 1;

  if (N < 2 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_cfg
    $fatal(1, "nbit_addsub_seq: illegal N/CHUNK combination");
  end

  state_t          r_state;
  state_t          w_state_next;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_acc;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic            r_msb_a;
  logic            r_msb_b;
  logic [N-1:0]    r_res;
  logic [3:0]      r_flags;

  logic [CHUNK-1:0] w_x;
  logic [CHUNK-1:0] w_y;
  logic [CHUNK-1:0] w_s;
  logic             w_cout;
  logic [N-1:0]     w_acc_next;
  logic [3:0]       w_flags;
  logic             w_last;

  assign w_last = (r_idx == IW'(K - 1));

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = BUSY;
      end
      BUSY: begin
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand slice for the current chunk index.
  always_comb begin
    w_x = '0;
    w_y = '0;
    for (int j = 0; j < K; j++) begin
      if (r_idx == IW'(j)) begin
        w_x = r_a[j*CHUNK +: CHUNK];
        w_y = r_b[j*CHUNK +: CHUNK];
      end
    end
  end

  chunk_adder #(.W(CHUNK)) u_chunk_adder (
    .x    (w_x),
    .y    (w_y),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // Accumulator with the current sum chunk merged in; on the last chunk this
  // is the complete result, so r and f load from it directly.
  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < K; j++) begin
      if (r_idx == IW'(j)) w_acc_next[j*CHUNK +: CHUNK] = w_s;
    end
  end

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_acc_next[N-1];
    w_flags[FLAG_Z] = (w_acc_next == '0);
    w_flags[FLAG_C] = w_cout;
    w_flags[FLAG_V] = (r_msb_a == r_msb_b) && (w_acc_next[N-1] != r_msb_a);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_msb_a <= 1'b0;
      r_msb_b <= 1'b0;
      r_res   <= '0;
      r_flags <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
            r_acc   <= '0;
            r_msb_a <= a[N-1];
            r_msb_b <= sub ? ~b[N-1] : b[N-1];
          end
        end
        BUSY: begin
          r_acc   <= w_acc_next;
          r_carry <= w_cout;
          if (w_last) begin
            r_res   <= w_acc_next;
            r_flags <= w_flags;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign r = r_res;
  assign f = r_flags;

endmodule : nbit_addsub_seq

// File: tb/tb_nbit_addsub_seq.sv
// Directed bench: one N=4/CHUNK=1 instance plus an N=8 group sweeping CHUNK.
module tb_nbit_addsub_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // N=4, CHUNK=1 instance
  logic       in_valid4 = 1'b0, in_ready4, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, r4, f4;
  logic       out_valid4, out_ready4 = 1'b0;

  nbit_addsub_seq #(.N(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .sub(sub4), .a(a4), .b(b4), .out_valid(out_valid4),
    .out_ready(out_ready4), .r(r4), .f(f4)
  );

  // N=8 group, CHUNK = 1,2,4,8 sharing the same stimulus
  logic       in_valid8 = 1'b0, sub8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ir8 [4];
  logic       ov8 [4];
  logic [7:0] r8  [4];
  logic [3:0] f8  [4];

  for (genvar g = 0; g < 4; g++) begin : g_n8
    nbit_addsub_seq #(.N(8), .CHUNK(1 << g)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(ir8[g]),
      .sub(sub8), .a(a8), .b(b8), .out_valid(ov8[g]),
      .out_ready(out_ready8), .r(r8[g]), .f(f8[g])
    );
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input string tag, input logic s, input logic [3:0] aa, bb, er, ef);
    int cyc;
    check({tag, ".in_ready"}, 32'(in_ready4), 1);
    a4 = aa; b4 = bb; sub4 = s; in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    cyc = 0;
    while (out_valid4 !== 1'b1 && cyc < 40) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 4);
    check({tag, ".r"}, 32'(r4), 32'(er));
    check({tag, ".f"}, 32'(f4), 32'(ef));
  endtask

  task automatic drain4(input string tag);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    check({tag, ".drain_ov"}, 32'(out_valid4), 0);
    check({tag, ".drain_rdy"}, 32'(in_ready4), 1);
  endtask

  task automatic op8(input string tag, input logic [7:0] aa, bb, er, input logic [3:0] ef);
    int lat [4];
    for (int g = 0; g < 4; g++) begin
      lat[g] = 0;
      check($sformatf("%s.c%0d.in_ready", tag, 1 << g), 32'(ir8[g]), 1);
    end
    a8 = aa; b8 = bb; sub8 = 1'b0; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      tick();
      for (int g = 0; g < 4; g++)
        if (lat[g] == 0 && ov8[g] === 1'b1) lat[g] = cyc;
    end
    for (int g = 0; g < 4; g++) begin
      check($sformatf("%s.c%0d.latency", tag, 1 << g), 32'(lat[g]), 32'(8 >> g));
      check($sformatf("%s.c%0d.r", tag, 1 << g), 32'(r8[g]), 32'(er));
      check($sformatf("%s.c%0d.f", tag, 1 << g), 32'(f8[g]), 32'(ef));
    end
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    for (int g = 0; g < 4; g++)
      check($sformatf("%s.c%0d.drain_ov", tag, 1 << g), 32'(ov8[g]), 0);
  endtask

  initial begin
    #2;
    check("reset.ov4", 32'(out_valid4), 0);
    check("reset.rdy4", 32'(in_ready4), 1);
    check("reset.r4", 32'(r4), 0);
    check("reset.f4", 32'(f4), 0);
    #21 rst_n = 1'b1;
    tick();

    // Basic adds
    op4("add_9_5", 1'b0, 4'b1001, 4'b0101, 4'b1110, 4'b1000); drain4("add_9_5");
    check("hold_idle.r4", 32'(r4), 32'hE);
    check("hold_idle.f4", 32'(f4), 32'h8);
    op4("add_f_1", 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'b0110); drain4("add_f_1");
    op4("add_1_1", 1'b0, 4'b0001, 4'b0001, 4'b0010, 4'b0000); drain4("add_1_1");
    op4("ovf_7_1", 1'b0, 4'b0111, 4'b0001, 4'b1000, 4'b1001); drain4("ovf_7_1");
    op4("sub_1_1", 1'b1, 4'b0001, 4'b0001, 4'b0000, 4'b0110); drain4("sub_1_1");
    op4("sub_0_1", 1'b1, 4'b0000, 4'b0001, 4'b1111, 4'b1000); drain4("sub_0_1");

    // Backpressure: DONE holds, in_valid pulses ignored
    op4("bp", 1'b0, 4'b0101, 4'b0110, 4'b1011, 4'b1001);
    for (int i = 0; i < 10; i++) begin
      in_valid4 = i[0];
      a4 = 4'(i + 3); b4 = 4'(i * 7); sub4 = ~i[1];
      tick();
      check($sformatf("bp.ov.%0d", i), 32'(out_valid4), 1);
      check($sformatf("bp.rdy.%0d", i), 32'(in_ready4), 0);
      check($sformatf("bp.r.%0d", i), 32'(r4), 32'hB);
      check($sformatf("bp.f.%0d", i), 32'(f4), 32'h9);
    end
    in_valid4 = 1'b0;
    drain4("bp");
    check("bp.after.r", 32'(r4), 32'hB);
    tick();
    check("bp.after.idle", 32'(in_ready4), 1);

    // Operands change every BUSY cycle; result must use the captured values
    a4 = 4'b0011; b4 = 4'b0010; sub4 = 1'b0; in_valid4 = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a4 = 4'(i * 5 + 7); b4 = 4'(15 - i); sub4 = ~sub4; in_valid4 = (i < 3);
      tick();
    end
    in_valid4 = 1'b0;
    check("chg.ov", 32'(out_valid4), 1);
    check("chg.r", 32'(r4), 32'h5);
    check("chg.f", 32'(f4), 32'h0);
    drain4("chg");

    // Latency sweep over CHUNK at N=8
    op8("sweep", 8'h7F, 8'h01, 8'h80, 4'b1001);

    // Reset in the third BUSY cycle of the CHUNK=1 instance
    a8 = 8'hAA; b8 = 8'h0F; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_busy.ov", 32'(ov8[0]), 0);
    check("rst_busy.r", 32'(r8[0]), 0);
    check("rst_busy.f", 32'(f8[0]), 0);
    check("rst_busy.rdy", 32'(ir8[0]), 1);
    #2 rst_n = 1'b1;
    tick();
    op8("post_rst", 8'h10, 8'h20, 8'h30, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_nbit_addsub_seq
